// File: rtl/periph_bus_master.sv
// Peripheral register bus initiator: queues read/write commands, issues one single-cycle
// strobe per transaction and returns captured read data on a valid/ready response stream.
module periph_bus_master #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [6:0] cmd_adr,
  input  logic [7:0] cmd_dat,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_dat,
  output logic       stb_o,
  output logic       we_o,
  output logic [6:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [2:0] LatInit = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StResp} state_e;

  state_e          state_q;
  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [2:0]      lat_q;
  logic            empty, push, pop;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != FullCnt);
  assign push      = cmd_valid && cmd_ready;
  // Only IDLE consumes the head, which keeps execution strictly in order.
  assign pop       = (state_q == StIdle) && !empty;
  assign idle      = empty && (state_q == StIdle) && !rsp_valid;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= {cmd_we, cmd_adr, cmd_dat};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      lat_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty) begin
            stb_o                 <= 1'b1;
            {we_o, adr_o, dat_o}  <= mem_q[rptr_q];
            state_q               <= StStrobe;
          end
        end
        StStrobe: begin
          stb_o <= 1'b0;
          if (we_o) begin
            state_q <= StIdle;
          end else begin
            lat_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (lat_q == '0) begin
            rsp_dat   <= dat_i;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: directed timing steps plus randomized traffic checked against
// an in-order transaction model with a register-file responder.
module tb_periph_bus_master;

  typedef struct packed {
    logic       we;
    logic [6:0] adr;
    logic [7:0] dat;
  } cmd_t;

  logic       clk, rst_i;
  logic       cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready;
  logic [6:0] cmd_adr, adr_o;
  logic [7:0] cmd_dat, rsp_dat, dat_o, dat_i;
  logic       stb_o, we_o, idle;

  logic       x_cmd_valid, x_cmd_ready, x_rsp_valid, x_stb, x_we, x_idle;
  logic [6:0] x_adr;
  logic [7:0] x_rsp_dat, x_dat_o, x_dat_i;
  logic [2:0] sh3;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   rand_rdy = 0;
  cmd_t exp_bus[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] mdl[128];
  logic [7:0] regs[128];
  logic       prev_stb = 0, prev_hold = 0;
  logic [7:0] prev_dat = '0;

  periph_bus_master #(.DEPTH(4), .RD_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .idle(idle)
  );

  periph_bus_master #(.DEPTH(4), .RD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_we(1'b0), .cmd_adr(7'h10),
    .cmd_dat(8'h00), .rsp_valid(x_rsp_valid), .rsp_ready(1'b1), .rsp_dat(x_rsp_dat),
    .stb_o(x_stb), .we_o(x_we), .adr_o(x_adr), .dat_o(x_dat_o), .dat_i(x_dat_i), .idle(x_idle)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Responder: registered read data one cycle after the strobe, zero otherwise.
  initial begin
    for (int a = 0; a < 128; a++) regs[a] = 8'hA1 + 8'(a);
    dat_i = 8'h00;
    forever begin
      @(posedge clk);
      if (stb_o && we_o) regs[adr_o] <= dat_o;
      dat_i <= (stb_o && !we_o) ? regs[adr_o] : 8'h00;
    end
  end

  // Three-cycle responder: data present only in cycle T+3.
  initial begin
    sh3 = '0;
    forever begin
      @(posedge clk);
      sh3 <= {sh3[1:0], x_stb && !x_we};
    end
  end
  assign x_dat_i = sh3[2] ? 8'h3C : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic monitor();
    cmd_t e;
    if (rst_i) begin
      prev_stb  = 0;
      prev_hold = 0;
      return;
    end
    if (prev_hold) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_dat", rsp_dat, prev_dat);
    end
    if (stb_o) begin
      chk("stb_single_cycle", prev_stb, 0);
      chk("stb_expected", exp_bus.size() != 0, 1);
      if (exp_bus.size() != 0) begin
        e = exp_bus.pop_front();
        chk("bus_we", we_o, e.we);
        chk("bus_adr", adr_o, e.adr);
        if (e.we) chk("bus_dat", dat_o, e.dat);
      end
    end
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) chk("rsp_dat", rsp_dat, exp_rsp.pop_front());
    end
    if (cmd_valid && cmd_ready) begin
      exp_bus.push_back({cmd_we, cmd_adr, cmd_dat});
      if (cmd_we) mdl[cmd_adr] = cmd_dat;
      else exp_rsp.push_back(mdl[cmd_adr]);
    end
    prev_stb  = stb_o;
    prev_hold = rsp_valid && !rsp_ready;
    prev_dat  = rsp_dat;
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    @(negedge clk);
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic we, input logic [6:0] adr, input logic [7:0] dat);
    bit ok = 0;
    cmd_valid = 1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cmd_valid = 0;
    chk("push_accept", ok, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (idle && exp_bus.size() == 0 && exp_rsp.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("drain", ok, 1);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mdl[a] = 8'hA1 + 8'(a);
    rst_i = 1; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; rsp_ready = 1;
    x_cmd_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    rst_i = 0;
    tick();

    // Single write: strobe exactly one cycle after acceptance.
    push(1, 7'h15, 8'h40);
    chk("w1_no_stb_yet", stb_o, 0);
    chk("w1_busy", idle, 0);
    tick();
    chk("w1_stb", stb_o, 1);
    chk("w1_we", we_o, 1);
    chk("w1_adr", adr_o, 7'h15);
    chk("w1_dat", dat_o, 8'h40);
    tick();
    chk("w1_stb_drop", stb_o, 0);
    chk("w1_no_rsp", rsp_valid, 0);
    chk("w1_idle", idle, 1);

    // Read with immediate accept: response at T+2 for one cycle.
    push(0, 7'h04, 8'h00);
    tick();
    chk("r1_stb", stb_o, 1);
    tick();
    chk("r1_t1_no_rsp", rsp_valid, 0);
    tick();
    chk("r1_t2_rsp", rsp_valid, 1);
    chk("r1_t2_dat", rsp_dat, 8'hA5);
    tick();
    chk("r1_t3_rsp_gone", rsp_valid, 0);

    // Stalled response blocks the queued write until the handshake.
    rsp_ready = 0;
    push(0, 7'h00, 8'h00);
    push(1, 7'h01, 8'h77);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("r2_no_stb", stb_o, 0);
      tick();
    end
    chk("r2_rsp_valid", rsp_valid, 1);
    chk("r2_rsp_dat", rsp_dat, 8'hA1);
    rsp_ready = 1;
    tick();
    chk("r2_rsp_cleared", rsp_valid, 0);
    chk("r2_write_waits", stb_o, 0);
    tick();
    chk("r2_write_stb", stb_o, 1);
    chk("r2_write_adr", adr_o, 7'h01);
    tick();

    // Fill the FIFO behind a stalled read.
    rsp_ready = 0;
    push(0, 7'h02, 8'h00);
    for (int i = 0; i < 4; i++) push(1, 7'h20 + 7'(i), 8'h10 + 8'(i));
    chk("fifo_full_ready", cmd_ready, 0);
    rsp_ready = 1;
    push(1, 7'h24, 8'h14);
    wait_drain();

    // Three-cycle read latency on the second instance.
    chk("l3_ready", x_cmd_ready, 1);
    x_cmd_valid = 1;
    tick();
    x_cmd_valid = 0;
    chk("l3_no_stb_yet", x_stb, 0);
    tick();
    chk("l3_stb", x_stb, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("l3_wait_no_rsp", x_rsp_valid, 0);
    end
    tick();
    chk("l3_rsp_valid", x_rsp_valid, 1);
    chk("l3_rsp_dat", x_rsp_dat, 8'h3C);
    tick();
    chk("l3_idle", x_idle, 1);

    // Random traffic with a randomly throttled consumer.
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      push(1'($urandom_range(0, 1)), 7'($urandom_range(0, 63)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    wait_drain();
    rand_rdy  = 0;
    rsp_ready = 1;

    // Reset while waiting on a read with two commands queued.
    push(0, 7'h30, 8'h00);
    push(1, 7'h7E, 8'h11);
    push(1, 7'h7F, 8'h22);
    chk("rst6_busy", idle, 0);
    rst_i = 1;
    tick();
    chk("rst6_stb", stb_o, 0);
    chk("rst6_rsp_valid", rsp_valid, 0);
    chk("rst6_idle", idle, 1);
    chk("rst6_cmd_ready", cmd_ready, 1);
    rst_i = 0;
    exp_bus.delete();
    exp_rsp.delete();
    repeat (10) tick();
    chk("rst6_still_idle", idle, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
